// File: rtl/dram_pkg.sv
// Shared types and command encodings for the DRAM request scheduler.
package dram_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACT,
    S_RCD_WAIT,
    S_COL,
    S_CAS_WAIT,
    S_REF,
    S_RFC_WAIT
  } state_t;

  localparam logic [14:0] REF_ADDR15 = 15'h700f;
  localparam logic        REF_CS0    = 1'b1;

  // Mode-register command bases, reserved for the register access path.
  localparam logic [14:0] RDREG_CODE = 15'h7e00;
  localparam logic [14:0] WRREG_CODE = 15'h7f00;

  localparam int CS_BIT  = 25;
  localparam int ROW_MSB = 24;
  localparam int ROW_LSB = 10;
  localparam int COL_MSB = 9;
  localparam int COL_LSB = 0;

endpackage

// File: rtl/dram_req_sched_if.sv
// Request bus and channel command bus between the memory bus and the scheduler.
interface dram_req_sched_if #(
  parameter int ADDR_W  = 26,
  parameter int BUSID_W = 9,
  parameter int DATA_W  = 64
);
  logic               req_en;
  logic               req_wr;
  logic [ADDR_W-1:0]  req_addr;
  logic [BUSID_W-1:0] req_busID;
  logic [DATA_W-1:0]  req_dataW;
  logic               req_stall;
  logic               req_ovf;
  logic               RAS;
  logic               CAS;
  logic               CS0;
  logic [14:0]        ADDR15;
  logic               cmd_wr;
  logic [BUSID_W-1:0] cmd_busID;
  logic [DATA_W-1:0]  cmd_dataW;
  logic               busy;

  modport master (
    output req_en, req_wr, req_addr, req_busID, req_dataW,
    input  req_stall, req_ovf, RAS, CAS, CS0, ADDR15,
    input  cmd_wr, cmd_busID, cmd_dataW, busy
  );

  modport slave (
    input  req_en, req_wr, req_addr, req_busID, req_dataW,
    output req_stall, req_ovf, RAS, CAS, CS0, ADDR15,
    output cmd_wr, cmd_busID, cmd_dataW, busy
  );
endinterface

// File: rtl/dram_req_fifo.sv
// Request FIFO with a registered full flag and a sticky overflow flag.
module dram_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             ovf
);
  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count, count_next;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop)      count_next = count + 1'b1;
    else if (do_pop && !do_push) count_next = count - 1'b1;
  end

  // NOTE: storage has no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      if (push && full) ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/dram_req_sched.sv
// Request scheduler: queues bus requests, issues ACT/CAS pairs and periodic refresh.
module dram_req_sched
  import dram_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 26,
  parameter int BUSID_W    = 9,
  parameter int DATA_W     = 64,
  parameter int T_RAS2CAS  = 8,
  parameter int T_CAS2DONE = 40,
  parameter int T_REFI     = 3120,
  parameter int T_RFC      = 40
) (
  input logic             clk,
  input logic             rst,
  dram_req_sched_if.slave bus
);
  localparam int ENTRY_W = 1 + ADDR_W + BUSID_W + DATA_W;
  localparam int CNT_W   = 16;
  localparam int RC_W    = $clog2(T_REFI + 1);

  localparam logic [CNT_W-1:0] LD_RCD = CNT_W'(T_RAS2CAS - 2);
  localparam logic [CNT_W-1:0] LD_CAS = CNT_W'(T_CAS2DONE - 2);
  localparam logic [CNT_W-1:0] LD_RFC = CNT_W'(T_RFC - 2);

  state_t             state, state_next;
  logic [CNT_W-1:0]   wait_cnt, cnt_next;
  logic [RC_W-1:0]    ref_cnt;
  logic               refresh_pend;

  logic [ENTRY_W-1:0] fifo_dout;
  logic               fifo_empty, fifo_pop;
  logic               head_wr;
  logic [ADDR_W-1:0]  head_addr;
  logic [BUSID_W-1:0] head_id;
  logic [DATA_W-1:0]  head_data;

  logic               cur_cs, cur_wr;
  logic [14:0]        cur_row;
  logic [9:0]         cur_col;
  logic [BUSID_W-1:0] cur_id;
  logic [DATA_W-1:0]  cur_data;

  logic               ras, cas, cs0;
  logic [14:0]        addr15;
  logic               cmd_wr;
  logic [BUSID_W-1:0] cmd_id;
  logic [DATA_W-1:0]  cmd_data;

  dram_req_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.req_en),
    .din   ({bus.req_wr, bus.req_addr, bus.req_busID, bus.req_dataW}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (bus.req_stall),
    .ovf   (bus.req_ovf)
  );

  assign {head_wr, head_addr, head_id, head_data} = fifo_dout;

  // Refresh interval timer; a pending refresh outranks queued requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt      <= RC_W'(T_REFI);
      refresh_pend <= 1'b0;
    end else begin
      if (state == S_REF) refresh_pend <= 1'b0;
      if (ref_cnt == '0) begin
        refresh_pend <= 1'b1;
        ref_cnt      <= RC_W'(T_REFI);
      end else begin
        ref_cnt <= ref_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= cnt_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    cnt_next   = wait_cnt;
    fifo_pop   = 1'b0;
    case (state)
      S_IDLE: begin
        if (refresh_pend) begin
          state_next = S_REF;
        end else if (!fifo_empty) begin
          state_next = S_ACT;
          fifo_pop   = 1'b1;
        end
      end
      S_ACT: begin
        state_next = S_RCD_WAIT;
        cnt_next   = LD_RCD;
      end
      S_RCD_WAIT: begin
        if (wait_cnt == '0) state_next = S_COL;
        else                cnt_next   = wait_cnt - 1'b1;
      end
      S_COL: begin
        state_next = S_CAS_WAIT;
        cnt_next   = LD_CAS;
      end
      S_CAS_WAIT: begin
        if (wait_cnt == '0) state_next = S_IDLE;
        else                cnt_next   = wait_cnt - 1'b1;
      end
      S_REF: begin
        state_next = S_RFC_WAIT;
        cnt_next   = LD_RFC;
      end
      S_RFC_WAIT: begin
        if (wait_cnt == '0) state_next = S_IDLE;
        else                cnt_next   = wait_cnt - 1'b1;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {cur_cs, cur_row, cur_col, cur_wr, cur_id, cur_data} <= '0;
    end else if (fifo_pop) begin
      cur_cs   <= head_addr[CS_BIT];
      cur_row  <= head_addr[ROW_MSB:ROW_LSB];
      cur_col  <= head_addr[COL_MSB:COL_LSB];
      cur_wr   <= head_wr;
      cur_id   <= head_id;
      cur_data <= head_data;
    end
  end

  // Loaded on entry to COL so they are valid with CAS and hold afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_wr   <= 1'b0;
      cmd_id   <= '0;
      cmd_data <= '0;
    end else if (state == S_RCD_WAIT && wait_cnt == '0) begin
      cmd_wr   <= cur_wr;
      cmd_id   <= cur_id;
      cmd_data <= cur_data;
    end
  end

  always_comb begin
    ras    = 1'b0;
    cas    = 1'b0;
    cs0    = 1'b0;
    addr15 = '0;
    case (state)
      S_ACT: begin
        ras    = 1'b1;
        cs0    = cur_cs;
        addr15 = cur_row;
      end
      S_COL: begin
        cas    = 1'b1;
        cs0    = cur_cs;
        addr15 = {5'b0, cur_col};
      end
      S_REF: begin
        ras    = 1'b1;
        cas    = 1'b1;
        cs0    = REF_CS0;
        addr15 = REF_ADDR15;
      end
      default: ;
    endcase
  end

  assign bus.RAS       = ras;
  assign bus.CAS       = cas;
  assign bus.CS0       = cs0;
  assign bus.ADDR15    = addr15;
  assign bus.cmd_wr    = cmd_wr;
  assign bus.cmd_busID = cmd_id;
  assign bus.cmd_dataW = cmd_data;
  assign bus.busy      = (state != S_IDLE) || !fifo_empty;

endmodule
